// File: rtl/mfb_checker_pkg.sv
// Shared constants and helpers for the MFB protocol checker.
package mfb_checker_pkg;

  localparam int unsigned ERR_WIDTH    = 6;
  localparam int unsigned LEN_WIDTH    = 16;

  localparam int unsigned SOF_IN_FRAME = 0;
  localparam int unsigned EOF_NO_FRAME = 1;
  localparam int unsigned POS_ORDER    = 2;
  localparam int unsigned HOLD         = 3;
  localparam int unsigned OVERSIZE     = 4;
  localparam int unsigned UNDERSIZE    = 5;

  // Length addition saturating at 2^16-1.
  function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = (s > 33'd65535) ? '1 : s[LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/mfb_checker_region.sv
// Combinational frame-tracking step for one MFB region.
module mfb_checker_region
  import mfb_checker_pkg::*;
#(
  parameter int unsigned REGION_SIZE     = 8,
  parameter int unsigned BLOCK_SIZE      = 8,
  parameter int unsigned MIN_FRAME_ITEMS = 1,
  parameter int unsigned MAX_FRAME_ITEMS = 16384,
  parameter int unsigned SOF_POS_W       = 3,
  parameter int unsigned EOF_POS_W       = 6
) (
  input  logic                 sof,
  input  logic                 eof,
  input  logic [SOF_POS_W-1:0] sof_pos,
  input  logic [EOF_POS_W-1:0] eof_pos,
  input  logic                 in_frame,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 next_in_frame,
  output logic [LEN_WIDTH-1:0] next_len,
  output logic                 eof_vld,
  output logic [LEN_WIDTH-1:0] eof_len,
  output logic [ERR_WIDTH-1:0] err
);

  logic [31:0] region_items;
  logic [31:0] start;
  logic [31:0] eof_items;

  // Classify SOF/EOF against the incoming frame state and update length.
  always_comb begin
    region_items  = 32'(REGION_SIZE * BLOCK_SIZE);
    start         = 32'(sof_pos) * 32'(BLOCK_SIZE);
    eof_items     = 32'(eof_pos) + 32'd1;
    next_in_frame = in_frame;
    next_len      = len;
    eof_vld       = 1'b0;
    eof_len       = '0;
    err           = '0;

    if (sof && eof) begin
      eof_vld = 1'b1;
      if (in_frame) begin
        // Old frame ends at EOF, new one opens at SOF after it.
        eof_len       = sat_add(32'(len), eof_items);
        err[POS_ORDER] = (32'(eof_pos) >= start);
        next_in_frame = 1'b1;
        next_len      = sat_add(32'd0, region_items - start);
      end else begin
        next_in_frame = 1'b0;
        next_len      = '0;
        if (32'(eof_pos) < start) begin
          err[POS_ORDER] = 1'b1;
        end else begin
          eof_len = sat_add(32'd0, eof_items - start);
        end
      end
    end else if (sof) begin
      err[SOF_IN_FRAME] = in_frame;
      next_in_frame     = 1'b1;
      next_len          = sat_add(32'd0, region_items - start);
    end else if (eof) begin
      if (in_frame) begin
        eof_vld       = 1'b1;
        eof_len       = sat_add(32'(len), eof_items);
        next_in_frame = 1'b0;
        next_len      = '0;
      end else begin
        err[EOF_NO_FRAME] = 1'b1;
      end
    end else if (in_frame) begin
      next_len = sat_add(32'(len), region_items);
    end

    if (eof_vld) begin
      err[OVERSIZE]  = (32'(eof_len) > MAX_FRAME_ITEMS);
      err[UNDERSIZE] = (32'(eof_len) < MIN_FRAME_ITEMS);
    end
  end

endmodule

// File: rtl/mfb_protocol_checker.sv
// Passive MFB bus checker: frame structure, length limits and hold rule.
module mfb_protocol_checker
  import mfb_checker_pkg::*;
#(
  parameter  int unsigned REGIONS         = 1,
  parameter  int unsigned REGION_SIZE     = 8,
  parameter  int unsigned BLOCK_SIZE      = 8,
  parameter  int unsigned ITEM_WIDTH      = 8,
  parameter  int unsigned META_WIDTH      = 0,
  parameter  int unsigned MIN_FRAME_ITEMS = 1,
  parameter  int unsigned MAX_FRAME_ITEMS = 16384,
  parameter  int unsigned CNT_WIDTH       = 32,
  localparam int unsigned DATA_W    = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH,
  localparam int unsigned META_W    = (META_WIDTH > 0) ? META_WIDTH : 1,
  localparam int unsigned SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int unsigned EOF_POS_W = (REGION_SIZE * BLOCK_SIZE > 1) ? $clog2(REGION_SIZE * BLOCK_SIZE) : 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [DATA_W-1:0]              DATA,
  input  logic [REGIONS*META_W-1:0]      META,
  input  logic [REGIONS*SOF_POS_W-1:0]   SOF_POS,
  input  logic [REGIONS*EOF_POS_W-1:0]   EOF_POS,
  input  logic [REGIONS-1:0]             SOF,
  input  logic [REGIONS-1:0]             EOF,
  input  logic                           SRC_RDY,
  input  logic                           DST_RDY,
  input  logic                           ERR_CLR,
  output logic [ERR_WIDTH-1:0]           ERR,
  output logic [ERR_WIDTH-1:0]           ERR_PULSE,
  output logic [CNT_WIDTH-1:0]           FRAME_CNT,
  output logic [LEN_WIDTH-1:0]           LAST_LEN,
  output logic                           LAST_LEN_VLD
);

  logic                               in_frame_q;
  logic [LEN_WIDTH-1:0]               len_q;
  logic [REGIONS:0]                   frame_c;
  logic [REGIONS:0][LEN_WIDTH-1:0]    len_c;
  logic [REGIONS-1:0]                 eof_vld;
  logic [REGIONS-1:0][LEN_WIDTH-1:0]  eof_len;
  logic [REGIONS-1:0][ERR_WIDTH-1:0]  r_err;

  logic                               hold_q;
  logic [DATA_W-1:0]                  data_q;
  logic [REGIONS*META_W-1:0]          meta_q;
  logic [REGIONS*SOF_POS_W-1:0]       sof_pos_q;
  logic [REGIONS*EOF_POS_W-1:0]       eof_pos_q;
  logic [REGIONS-1:0]                 sof_q;
  logic [REGIONS-1:0]                 eof_q;

  logic                               accept;
  logic                               hold_err;
  logic [ERR_WIDTH-1:0]               word_err;
  logic [ERR_WIDTH-1:0]               new_err;
  logic [CNT_WIDTH-1:0]               eof_cnt;
  logic [LEN_WIDTH-1:0]               last_len_n;
  logic                               any_eof;

  assign frame_c[0] = in_frame_q;
  assign len_c[0]   = len_q;

  for (genvar r = 0; r < REGIONS; r++) begin : g_region
    mfb_checker_region #(
      .REGION_SIZE     (REGION_SIZE),
      .BLOCK_SIZE      (BLOCK_SIZE),
      .MIN_FRAME_ITEMS (MIN_FRAME_ITEMS),
      .MAX_FRAME_ITEMS (MAX_FRAME_ITEMS),
      .SOF_POS_W       (SOF_POS_W),
      .EOF_POS_W       (EOF_POS_W)
    ) u_region (
      .sof           (SOF[r]),
      .eof           (EOF[r]),
      .sof_pos       (SOF_POS[r*SOF_POS_W +: SOF_POS_W]),
      .eof_pos       (EOF_POS[r*EOF_POS_W +: EOF_POS_W]),
      .in_frame      (frame_c[r]),
      .len           (len_c[r]),
      .next_in_frame (frame_c[r+1]),
      .next_len      (len_c[r+1]),
      .eof_vld       (eof_vld[r]),
      .eof_len       (eof_len[r]),
      .err           (r_err[r])
    );
  end

  // Merge per-region results; the highest ended region supplies LAST_LEN.
  always_comb begin
    word_err   = '0;
    eof_cnt    = '0;
    last_len_n = '0;
    any_eof    = 1'b0;
    for (int unsigned r = 0; r < REGIONS; r++) begin
      word_err = word_err | r_err[r];
      if (eof_vld[r]) begin
        eof_cnt    = eof_cnt + CNT_WIDTH'(1);
        last_len_n = eof_len[r];
        any_eof    = 1'b1;
      end
    end
  end

  // Hold violations are flagged even on non-accepted cycles.
  always_comb begin
    accept   = SRC_RDY && DST_RDY;
    hold_err = hold_q && (!SRC_RDY || DATA != data_q || META != meta_q ||
                          SOF != sof_q || EOF != eof_q ||
                          SOF_POS != sof_pos_q || EOF_POS != eof_pos_q);
    new_err       = accept ? word_err : '0;
    new_err[HOLD] = new_err[HOLD] | hold_err;
  end

  // Frame state, counters and error registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_frame_q   <= 1'b0;
      len_q        <= '0;
      ERR          <= '0;
      ERR_PULSE    <= '0;
      FRAME_CNT    <= '0;
      LAST_LEN     <= '0;
      LAST_LEN_VLD <= 1'b0;
    end else begin
      ERR_PULSE    <= new_err;
      ERR          <= ERR_CLR ? new_err : (ERR | new_err);
      LAST_LEN_VLD <= accept && any_eof;
      if (accept) begin
        in_frame_q <= frame_c[REGIONS];
        len_q      <= len_c[REGIONS];
        FRAME_CNT  <= FRAME_CNT + eof_cnt;
        if (any_eof) begin
          LAST_LEN <= last_len_n;
        end
      end
    end
  end

  // Snapshot of the bus for the hold check on the following cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_q    <= 1'b0;
      data_q    <= '0;
      meta_q    <= '0;
      sof_pos_q <= '0;
      eof_pos_q <= '0;
      sof_q     <= '0;
      eof_q     <= '0;
    end else begin
      hold_q    <= SRC_RDY && !DST_RDY;
      data_q    <= DATA;
      meta_q    <= META;
      sof_pos_q <= SOF_POS;
      eof_pos_q <= EOF_POS;
      sof_q     <= SOF;
      eof_q     <= EOF;
    end
  end

endmodule

// File: tb/tb_mfb_protocol_checker.sv
// Scoreboard bench for mfb_protocol_checker (2 regions x 4 blocks x 8 items).
module tb_mfb_protocol_checker;

  logic         CLK;
  logic         RESET;
  logic [511:0] DATA;
  logic [1:0]   META;
  logic [3:0]   SOF_POS;
  logic [9:0]   EOF_POS;
  logic [1:0]   SOF;
  logic [1:0]   EOF;
  logic         SRC_RDY;
  logic         DST_RDY;
  logic         ERR_CLR;
  logic [5:0]   ERR;
  logic [5:0]   ERR_PULSE;
  logic [31:0]  FRAME_CNT;
  logic [15:0]  LAST_LEN;
  logic         LAST_LEN_VLD;

  typedef struct {
    int          id;
    logic [5:0]  err;
    logic [5:0]  pulse;
    logic [31:0] cnt;
    logic [15:0] len;
    logic        vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mfb_protocol_checker #(
    .REGIONS         (2),
    .REGION_SIZE     (4),
    .BLOCK_SIZE      (8),
    .ITEM_WIDTH      (8),
    .META_WIDTH      (0),
    .MIN_FRAME_ITEMS (1),
    .MAX_FRAME_ITEMS (64),
    .CNT_WIDTH       (32)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DATA         (DATA),
    .META         (META),
    .SOF_POS      (SOF_POS),
    .EOF_POS      (EOF_POS),
    .SOF          (SOF),
    .EOF          (EOF),
    .SRC_RDY      (SRC_RDY),
    .DST_RDY      (DST_RDY),
    .ERR_CLR      (ERR_CLR),
    .ERR          (ERR),
    .ERR_PULSE    (ERR_PULSE),
    .FRAME_CNT    (FRAME_CNT),
    .LAST_LEN     (LAST_LEN),
    .LAST_LEN_VLD (LAST_LEN_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL T%0d.%s: got %0h expected %0h", id, name, act, exp);
    end
  endtask

  // Monitor: every edge produces registered outputs for the word driven before it.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.id, "err",          32'(ERR),          32'(e.err));
      chk(e.id, "err_pulse",    32'(ERR_PULSE),    32'(e.pulse));
      chk(e.id, "frame_cnt",    FRAME_CNT,         e.cnt);
      chk(e.id, "last_len",     32'(LAST_LEN),     32'(e.len));
      chk(e.id, "last_len_vld", 32'(LAST_LEN_VLD), 32'(e.vld));
    end
  end

  task automatic cyc(input int id, input logic rst, input logic src, input logic dst, input logic clr,
                     input logic [1:0] sof, input logic [1:0] eof,
                     input logic [1:0] sp0, input logic [1:0] sp1,
                     input logic [4:0] ep0, input logic [4:0] ep1, input logic [31:0] seed,
                     input logic [5:0] e_err, input logic [5:0] e_pulse,
                     input logic [31:0] e_cnt, input logic [15:0] e_len, input logic e_vld);
    @(negedge CLK);
    RESET   = rst;
    SRC_RDY = src;
    DST_RDY = dst;
    ERR_CLR = clr;
    SOF     = sof;
    EOF     = eof;
    SOF_POS = {sp1, sp0};
    EOF_POS = {ep1, ep0};
    DATA    = {16{seed}};
    META    = seed[1:0];
    exp_q.push_back('{id, e_err, e_pulse, e_cnt, e_len, e_vld});
    @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1; SRC_RDY = 1'b0; DST_RDY = 1'b1; ERR_CLR = 1'b0;
    SOF = '0; EOF = '0; SOF_POS = '0; EOF_POS = '0; DATA = '0; META = '0;

    //  id rst src dst clr sof    eof    sp0 sp1 ep0 ep1 seed        err    pulse  cnt len  vld
    cyc( 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 0,   0, 0);
    cyc( 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 0,   0, 0);
    // single-region frame of 32 items
    cyc( 2, 0, 1, 1, 0, 2'b01, 2'b01, 0, 0, 31,  0, 32'h11,     6'h00, 6'h00, 1,  32, 1);
    cyc( 3, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 1,  32, 0);
    // frame across two words: 16 + 10 items
    cyc( 4, 0, 1, 1, 0, 2'b10, 2'b00, 0, 2,  0,  0, 32'h0,      6'h00, 6'h00, 1,  32, 0);
    cyc( 5, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0,  9,  0, 32'h0,      6'h00, 6'h00, 2,  26, 1);
    // SOF inside an open frame, sticky until cleared
    cyc( 6, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 2,  26, 0);
    cyc( 7, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0,  0,  0, 32'h0,      6'h01, 6'h01, 2,  26, 0);
    cyc( 8, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h01, 6'h00, 2,  26, 0);
    cyc( 9, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 2,  26, 0);
    // restarted frame is 64 items, one more makes it oversize
    cyc(10, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0,  0,  0, 32'h0,      6'h10, 6'h10, 3,  65, 1);
    // clear coinciding with a new EOF_NO_FRAME keeps only the new error
    cyc(11, 0, 1, 1, 1, 2'b00, 2'b01, 0, 0,  0,  0, 32'h0,      6'h02, 6'h02, 3,  65, 0);
    cyc(12, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 3,  65, 0);
    // backpressure with DATA changing
    cyc(13, 0, 1, 0, 0, 2'b01, 2'b00, 3, 0,  0,  0, 32'hA5A5,   6'h00, 6'h00, 3,  65, 0);
    cyc(14, 0, 1, 1, 0, 2'b01, 2'b00, 3, 0,  0,  0, 32'h5A5A,   6'h08, 6'h08, 3,  65, 0);
    cyc(15, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 3,  65, 0);
    // backpressure with everything held: 40 + 4 items
    cyc(16, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0,  3,  0, 32'hC3C3,   6'h00, 6'h00, 3,  65, 0);
    cyc(17, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0,  3,  0, 32'hC3C3,   6'h00, 6'h00, 4,  44, 1);
    cyc(18, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 4,  44, 0);
    // 129-item frame
    cyc(19, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 4,  44, 0);
    cyc(20, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 4,  44, 0);
    cyc(21, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0,  0,  0, 32'h0,      6'h10, 6'h10, 5, 129, 1);
    cyc(22, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 5, 129, 0);
    // reset mid-frame, then an orphan EOF
    cyc(23, 0, 1, 1, 0, 2'b01, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 5, 129, 0);
    cyc(24, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 0,   0, 0);
    cyc(25, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0,  5,  0, 32'h0,      6'h02, 6'h02, 0,   0, 0);
    // two single-region frames in one word: LAST_LEN from region 1
    cyc(26, 0, 1, 1, 1, 2'b11, 2'b11, 0, 1,  7, 19, 32'h0,      6'h00, 6'h00, 2,  12, 0 | 1'b1);
    // region 1 closes 21-item frame and opens another
    cyc(27, 0, 1, 1, 0, 2'b11, 2'b10, 2, 1,  0,  4, 32'h0,      6'h00, 6'h00, 3,  21, 1);
    cyc(28, 0, 1, 1, 0, 2'b00, 2'b01, 0, 0, 31,  0, 32'h0,      6'h00, 6'h00, 4,  56, 1);
    // in-frame SOF+EOF with EOF at/after the SOF block
    cyc(29, 0, 1, 1, 0, 2'b10, 2'b00, 0, 3,  0,  0, 32'h0,      6'h00, 6'h00, 4,  56, 0);
    cyc(30, 0, 1, 1, 0, 2'b01, 2'b01, 1, 0, 10,  0, 32'h0,      6'h04, 6'h04, 5,  19, 1);
    cyc(31, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0,  0,  0, 32'h0,      6'h00, 6'h00, 5,  19, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
